// File: rtl/ctl_unit_ldst.sv
// Control sequencer for the PC/IR/MAR/MDR/Y/Z datapath.
// Walks fetch (T0..T2) then ld, ldi, st, nop or halt, one state per clock.
module ctl_unit_ldst #(
  parameter logic [4:0] OP_LD   = 5'b00000,
  parameter logic [4:0] OP_LDI  = 5'b00001,
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] OP_NOP  = 5'b11010,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic [4:0] opcode,
  output logic       PC_out,
  output logic       Zlo_out,
  output logic       MDR_out,
  output logic       Cout,
  output logic       BAout,
  output logic       Rout,
  output logic       Gra,
  output logic       Grb,
  output logic       MAR_rd,
  output logic       MDR_rd,
  output logic       IR_rd,
  output logic       Y_rd,
  output logic       Zlo_rd,
  output logic       Rin,
  output logic       IncPC,
  output logic       alu_add,
  output logic       Read,
  output logic       Write,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state_view
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  state_t state;
  state_t state_nxt;

  logic is_ld;
  logic is_ldi;
  logic is_st;
  logic is_nop;
  logic is_halt;
  logic is_mem;

  assign is_ld   = (opcode == OP_LD);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_st   = (opcode == OP_ST);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);
  assign is_mem  = is_ld | is_ldi | is_st;

  assign state_view = state;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    unique case (state)
      S_IDLE: state_nxt = run ? S_T0 : S_IDLE;
      S_T0:   state_nxt = S_T1;
      S_T1:   state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (is_mem) begin
          state_nxt = S_T4;
        end else if (is_halt) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = (is_ld | is_st) ? S_T6 : S_IDLE;
      S_T6:   state_nxt = (is_ld | is_st) ? S_T7 : S_IDLE;
      S_T7:   state_nxt = S_IDLE;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore decode: strobes follow state, opcode only selects the T3+ path.
  always_comb begin
    PC_out     = 1'b0;
    Zlo_out    = 1'b0;
    MDR_out    = 1'b0;
    Cout       = 1'b0;
    BAout      = 1'b0;
    Rout       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    MAR_rd     = 1'b0;
    MDR_rd     = 1'b0;
    IR_rd      = 1'b0;
    Y_rd       = 1'b0;
    Zlo_rd     = 1'b0;
    Rin        = 1'b0;
    IncPC      = 1'b0;
    alu_add    = 1'b0;
    Read       = 1'b0;
    Write      = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    unique case (state)
      S_T0: begin
        PC_out = 1'b1;
        MAR_rd = 1'b1;
        IncPC  = 1'b1;
      end
      S_T1: begin
        Read   = 1'b1;
        MDR_rd = 1'b1;
      end
      S_T2: begin
        MDR_out = 1'b1;
        IR_rd   = 1'b1;
      end
      S_T3: begin
        unique case (1'b1)
          is_mem: begin
            Grb   = 1'b1;
            BAout = 1'b1;
            Y_rd  = 1'b1;
          end
          is_halt: ;
          is_nop:  instr_done = 1'b1;
          default: instr_done = 1'b1;
        endcase
      end
      S_T4: begin
        Cout    = 1'b1;
        alu_add = 1'b1;
        Zlo_rd  = 1'b1;
      end
      S_T5: begin
        Zlo_out = 1'b1;
        if (is_ldi) begin
          Gra        = 1'b1;
          Rin        = 1'b1;
          instr_done = 1'b1;
        end else begin
          MAR_rd = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          Read   = 1'b1;
          MDR_rd = 1'b1;
        end else if (is_st) begin
          Gra    = 1'b1;
          Rout   = 1'b1;
          MDR_rd = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDR_out    = 1'b1;
          Gra        = 1'b1;
          Rin        = 1'b1;
          instr_done = 1'b1;
        end else if (is_st) begin
          Write      = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
